// File: rtl/control_sequencer_pkg.sv
`default_nettype none
//============================================================================
// Module : control_sequencer_pkg
// Brief  : Shared opcode, ALU-op, state and IR-field definitions for the
//          hardwired control sequencer and its datapath neighbours.
// Rev    : 1.0  initial release
//============================================================================
package control_sequencer_pkg;

  // Sequencer states: fetch F0..F3, execute E0..E4, terminal HALTED
  typedef enum logic [3:0] {
    S_F0     = 4'd0,
    S_F1     = 4'd1,
    S_F2     = 4'd2,
    S_F3     = 4'd3,
    S_E0     = 4'd4,
    S_E1     = 4'd5,
    S_E2     = 4'd6,
    S_E3     = 4'd7,
    S_E4     = 4'd8,
    S_HALTED = 4'd9
  } state_t;

  // Instruction classes sharing one execute recipe
  typedef enum logic [3:0] {
    CLS_ALU3    = 4'd0,
    CLS_ALUI    = 4'd1,
    CLS_UNARY   = 4'd2,
    CLS_MULDIV  = 4'd3,
    CLS_LD      = 4'd4,
    CLS_ST      = 4'd5,
    CLS_MFHI    = 4'd6,
    CLS_MFLO    = 4'd7,
    CLS_NOP     = 4'd8,
    CLS_HALT    = 4'd9,
    CLS_ILLEGAL = 4'd10
  } op_class_t;

  // Opcodes (IR[31:27])
  localparam logic [4:0] c_op_add  = 5'h00;
  localparam logic [4:0] c_op_sub  = 5'h01;
  localparam logic [4:0] c_op_and  = 5'h02;
  localparam logic [4:0] c_op_or   = 5'h03;
  localparam logic [4:0] c_op_shr  = 5'h04;
  localparam logic [4:0] c_op_shl  = 5'h05;
  localparam logic [4:0] c_op_ror  = 5'h06;
  localparam logic [4:0] c_op_rol  = 5'h07;
  localparam logic [4:0] c_op_addi = 5'h08;
  localparam logic [4:0] c_op_andi = 5'h09;
  localparam logic [4:0] c_op_ori  = 5'h0A;
  localparam logic [4:0] c_op_mul  = 5'h0B;
  localparam logic [4:0] c_op_div  = 5'h0C;
  localparam logic [4:0] c_op_neg  = 5'h0D;
  localparam logic [4:0] c_op_not  = 5'h0E;
  localparam logic [4:0] c_op_ld   = 5'h0F;
  localparam logic [4:0] c_op_st   = 5'h10;
  localparam logic [4:0] c_op_mfhi = 5'h11;
  localparam logic [4:0] c_op_mflo = 5'h12;
  localparam logic [4:0] c_op_nop  = 5'h13;
  localparam logic [4:0] c_op_halt = 5'h14;

  // ALU operation codes, shared with the ALU; ADD is the idle value
  localparam logic [3:0] c_alu_add = 4'h0;
  localparam logic [3:0] c_alu_sub = 4'h1;
  localparam logic [3:0] c_alu_and = 4'h2;
  localparam logic [3:0] c_alu_or  = 4'h3;
  localparam logic [3:0] c_alu_shr = 4'h4;
  localparam logic [3:0] c_alu_shl = 4'h5;
  localparam logic [3:0] c_alu_ror = 4'h6;
  localparam logic [3:0] c_alu_rol = 4'h7;
  localparam logic [3:0] c_alu_mul = 4'h8;
  localparam logic [3:0] c_alu_div = 4'h9;
  localparam logic [3:0] c_alu_neg = 4'hA;
  localparam logic [3:0] c_alu_not = 4'hB;

  // IR field bit positions
  localparam int c_op_msb = 31;
  localparam int c_op_lsb = 27;
  localparam int c_ra_msb = 26;
  localparam int c_ra_lsb = 23;
  localparam int c_rb_msb = 22;
  localparam int c_rb_lsb = 19;
  localparam int c_rc_msb = 18;
  localparam int c_rc_lsb = 15;

  // Per-state control word before GPR field decoding
  typedef struct packed {
    logic       pc_in;
    logic       pc_out;
    logic       mar_in;
    logic       ir_in;
    logic       y_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       hi_in;
    logic       hi_out;
    logic       lo_in;
    logic       lo_out;
    logic       zlow_in;
    logic       zhigh_in;
    logic       zlow_out;
    logic       zhigh_out;
    logic       c_out;
    logic       one_out;
    logic       read;
    logic       write;
    logic       ra_in;
    logic       ra_out;
    logic       rb_out;
    logic       rc_out;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or,
      c_op_shr, c_op_shl, c_op_ror, c_op_rol: op_class = CLS_ALU3;
      c_op_addi, c_op_andi, c_op_ori:         op_class = CLS_ALUI;
      c_op_neg, c_op_not:                     op_class = CLS_UNARY;
      c_op_mul, c_op_div:                     op_class = CLS_MULDIV;
      c_op_ld:                                op_class = CLS_LD;
      c_op_st:                                op_class = CLS_ST;
      c_op_mfhi:                              op_class = CLS_MFHI;
      c_op_mflo:                              op_class = CLS_MFLO;
      c_op_nop:                               op_class = CLS_NOP;
      c_op_halt:                              op_class = CLS_HALT;
      default:                                op_class = CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      c_op_sub:            alu_code = c_alu_sub;
      c_op_and, c_op_andi: alu_code = c_alu_and;
      c_op_or, c_op_ori:   alu_code = c_alu_or;
      c_op_shr:            alu_code = c_alu_shr;
      c_op_shl:            alu_code = c_alu_shl;
      c_op_ror:            alu_code = c_alu_ror;
      c_op_rol:            alu_code = c_alu_rol;
      c_op_mul:            alu_code = c_alu_mul;
      c_op_div:            alu_code = c_alu_div;
      c_op_neg:            alu_code = c_alu_neg;
      c_op_not:            alu_code = c_alu_not;
      default:             alu_code = c_alu_add;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
//============================================================================
// Module : control_sequencer_if
// Brief  : Sequencer <-> datapath control bundle. master = sequencer,
//          slave = datapath / memory side.
// Rev    : 1.0  initial release
//============================================================================
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic        run;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        PCin, PCout, MARin, IRin, Yin, MDRin, MDRout;
  logic        HIin, HIout, LOin, LOout;
  logic        Zlowin, Zhighin, Zlowout, Zhighout;
  logic        Cout, Oneout;
  logic [3:0]  ALUop;
  logic        Read, Write;
  logic        halted, fault;

  modport master (
    input  run, IR, mem_ready,
    output Rin, Rout, PCin, PCout, MARin, IRin, Yin, MDRin, MDRout,
           HIin, HIout, LOin, LOout, Zlowin, Zhighin, Zlowout, Zhighout,
           Cout, Oneout, ALUop, Read, Write, halted, fault
  );

  modport slave (
    output run, IR, mem_ready,
    input  Rin, Rout, PCin, PCout, MARin, IRin, Yin, MDRin, MDRout,
           HIin, HIout, LOin, LOout, Zlowin, Zhighin, Zlowout, Zhighout,
           Cout, Oneout, ALUop, Read, Write, halted, fault
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_reg_field_decode.sv
`default_nettype none
//============================================================================
// Module : control_sequencer_reg_field_decode
// Brief  : 4-bit register field plus enable to 16-bit one-hot select.
// Rev    : 1.0  initial release
//============================================================================
module control_sequencer_reg_field_decode (
  input  wire logic [3:0]  i_field,
  input  wire logic        i_en,
  output logic      [15:0] o_onehot
);
  // One-hot select, all zero when the field is not in use this state
  assign o_onehot = i_en ? (16'd1 << i_field) : 16'd0;
endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
//============================================================================
// Module : control_sequencer
// Brief  : Hardwired Moore control unit for the phase-1 bus datapath:
//          fetch F0..F3, decode, execute E0..E4, memory-wait timeout.
// Rev    : 1.0  initial release
//============================================================================
module control_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input wire logic           clock,
  input wire logic           clear,
  control_sequencer_if.master bus
);
  import control_sequencer_pkg::*;

  localparam int c_wait_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [c_wait_w-1:0] c_wait_limit = c_wait_w'(MEM_TIMEOUT);
  localparam logic [c_wait_w-1:0] c_wait_one   = c_wait_w'(1);

  state_t              r_state;
  logic [c_wait_w-1:0] r_wait;
  logic                r_fault;

  logic [4:0]          w_op;
  logic [3:0]          w_ra, w_rb, w_rc;
  op_class_t           w_cls;
  logic [3:0]          w_alu;
  logic                w_mem_state, w_mem_wait, w_timeout;
  logic [c_wait_w-1:0] w_wait_next;
  ctrl_t               w_ctl;
  logic [15:0]         w_dec_ra, w_dec_rb, w_dec_rc;
  logic                w_unused_ir;

  assign w_op  = bus.IR[c_op_msb:c_op_lsb];
  assign w_ra  = bus.IR[c_ra_msb:c_ra_lsb];
  assign w_rb  = bus.IR[c_rb_msb:c_rb_lsb];
  assign w_rc  = bus.IR[c_rc_msb:c_rc_lsb];
  assign w_cls = op_class(w_op);
  assign w_alu = alu_code(w_op);
  // The constant field is consumed by the datapath, not here
  assign w_unused_ir = &{1'b0, bus.IR[14:0]};

  // Memory states hold their strobes until mem_ready; the wait count bounds that
  assign w_mem_state = (r_state == S_F1) ||
                       (r_state == S_E3 && w_cls == CLS_LD) ||
                       (r_state == S_E4 && w_cls == CLS_ST);
  assign w_mem_wait  = w_mem_state && !bus.mem_ready;
  assign w_wait_next = r_wait + c_wait_one;
  assign w_timeout   = w_mem_wait && (MEM_TIMEOUT != 0) && (w_wait_next == c_wait_limit);

  // State register, memory wait counter and sticky fault
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_F0;
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_wait <= '0;
      if (w_mem_wait) begin
        if (w_timeout) begin
          r_state <= S_HALTED;
          r_fault <= 1'b1;
        end else if (MEM_TIMEOUT != 0) begin
          r_wait <= w_wait_next;
        end
      end else begin
        case (r_state)
          S_F0: if (bus.run) r_state <= S_F1;
          S_F1: r_state <= S_F2;
          S_F2: r_state <= S_F3;
          S_F3: r_state <= S_E0;
          S_E0: begin
            case (w_cls)
              CLS_HALT: r_state <= S_HALTED;
              CLS_ILLEGAL: begin
                r_fault <= 1'b1;
                r_state <= S_F0;
              end
              CLS_MFHI, CLS_MFLO, CLS_NOP: r_state <= S_F0;
              default: r_state <= S_E1;
            endcase
          end
          S_E1: r_state <= (w_cls == CLS_UNARY) ? S_F0 : S_E2;
          S_E2: r_state <= (w_cls == CLS_ALU3 || w_cls == CLS_ALUI) ? S_F0 : S_E3;
          S_E3: r_state <= (w_cls == CLS_MULDIV) ? S_F0 : S_E4;
          S_E4: r_state <= S_F0;
          S_HALTED: r_state <= S_HALTED;
          default: r_state <= S_F0;
        endcase
      end
    end
  end

  // Control word decoded from state and IR; forced idle while clear is high
  always_comb begin
    w_ctl        = '0;
    w_ctl.alu_op = c_alu_add;
    if (!clear) begin
      case (r_state)
        S_F0: begin
          if (bus.run) begin
            w_ctl.pc_out = 1'b1;
            w_ctl.mar_in = 1'b1;
            w_ctl.y_in   = 1'b1;
          end
        end
        S_F1: begin
          w_ctl.one_out = 1'b1;
          w_ctl.zlow_in = 1'b1;
          w_ctl.read    = 1'b1;
          w_ctl.mdr_in  = 1'b1;
        end
        S_F2: begin
          w_ctl.zlow_out = 1'b1;
          w_ctl.pc_in    = 1'b1;
        end
        S_F3: begin
          w_ctl.mdr_out = 1'b1;
          w_ctl.ir_in   = 1'b1;
        end
        S_E0: begin
          case (w_cls)
            CLS_ALU3, CLS_ALUI, CLS_LD, CLS_ST: begin
              w_ctl.rb_out = 1'b1;
              w_ctl.y_in   = 1'b1;
            end
            CLS_UNARY: begin
              w_ctl.rb_out  = 1'b1;
              w_ctl.alu_op  = w_alu;
              w_ctl.zlow_in = 1'b1;
            end
            CLS_MULDIV: begin
              w_ctl.ra_out = 1'b1;
              w_ctl.y_in   = 1'b1;
            end
            CLS_MFHI: begin
              w_ctl.hi_out = 1'b1;
              w_ctl.ra_in  = 1'b1;
            end
            CLS_MFLO: begin
              w_ctl.lo_out = 1'b1;
              w_ctl.ra_in  = 1'b1;
            end
            default: ;
          endcase
        end
        S_E1: begin
          case (w_cls)
            CLS_ALU3: begin
              w_ctl.rc_out  = 1'b1;
              w_ctl.alu_op  = w_alu;
              w_ctl.zlow_in = 1'b1;
            end
            CLS_ALUI: begin
              w_ctl.c_out   = 1'b1;
              w_ctl.alu_op  = w_alu;
              w_ctl.zlow_in = 1'b1;
            end
            CLS_UNARY: begin
              w_ctl.zlow_out = 1'b1;
              w_ctl.ra_in    = 1'b1;
            end
            CLS_MULDIV: begin
              w_ctl.rb_out   = 1'b1;
              w_ctl.alu_op   = w_alu;
              w_ctl.zlow_in  = 1'b1;
              w_ctl.zhigh_in = 1'b1;
            end
            CLS_LD, CLS_ST: begin
              w_ctl.c_out   = 1'b1;
              w_ctl.zlow_in = 1'b1;
            end
            default: ;
          endcase
        end
        S_E2: begin
          case (w_cls)
            CLS_ALU3, CLS_ALUI: begin
              w_ctl.zlow_out = 1'b1;
              w_ctl.ra_in    = 1'b1;
            end
            CLS_MULDIV: begin
              w_ctl.zlow_out = 1'b1;
              w_ctl.lo_in    = 1'b1;
            end
            CLS_LD, CLS_ST: begin
              w_ctl.zlow_out = 1'b1;
              w_ctl.mar_in   = 1'b1;
            end
            default: ;
          endcase
        end
        S_E3: begin
          case (w_cls)
            CLS_MULDIV: begin
              w_ctl.zhigh_out = 1'b1;
              w_ctl.hi_in     = 1'b1;
            end
            CLS_LD: begin
              w_ctl.read   = 1'b1;
              w_ctl.mdr_in = 1'b1;
            end
            CLS_ST: begin
              w_ctl.ra_out = 1'b1;
              w_ctl.mdr_in = 1'b1;
            end
            default: ;
          endcase
        end
        S_E4: begin
          case (w_cls)
            CLS_LD: begin
              w_ctl.mdr_out = 1'b1;
              w_ctl.ra_in   = 1'b1;
            end
            CLS_ST: w_ctl.write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  control_sequencer_reg_field_decode u_dec_ra (
    .i_field  (w_ra),
    .i_en     (w_ctl.ra_in | w_ctl.ra_out),
    .o_onehot (w_dec_ra)
  );

  control_sequencer_reg_field_decode u_dec_rb (
    .i_field  (w_rb),
    .i_en     (w_ctl.rb_out),
    .o_onehot (w_dec_rb)
  );

  control_sequencer_reg_field_decode u_dec_rc (
    .i_field  (w_rc),
    .i_en     (w_ctl.rc_out),
    .o_onehot (w_dec_rc)
  );

  // Only Ra is ever a destination; any of the three fields may drive the bus
  assign bus.Rin      = w_ctl.ra_in ? w_dec_ra : 16'd0;
  assign bus.Rout     = (w_ctl.ra_out ? w_dec_ra : 16'd0) | w_dec_rb | w_dec_rc;
  assign bus.PCin     = w_ctl.pc_in;
  assign bus.PCout    = w_ctl.pc_out;
  assign bus.MARin    = w_ctl.mar_in;
  assign bus.IRin     = w_ctl.ir_in;
  assign bus.Yin      = w_ctl.y_in;
  assign bus.MDRin    = w_ctl.mdr_in;
  assign bus.MDRout   = w_ctl.mdr_out;
  assign bus.HIin     = w_ctl.hi_in;
  assign bus.HIout    = w_ctl.hi_out;
  assign bus.LOin     = w_ctl.lo_in;
  assign bus.LOout    = w_ctl.lo_out;
  assign bus.Zlowin   = w_ctl.zlow_in;
  assign bus.Zhighin  = w_ctl.zhigh_in;
  assign bus.Zlowout  = w_ctl.zlow_out;
  assign bus.Zhighout = w_ctl.zhigh_out;
  assign bus.Cout     = w_ctl.c_out;
  assign bus.Oneout   = w_ctl.one_out;
  assign bus.ALUop    = w_ctl.alu_op;
  assign bus.Read     = w_ctl.read;
  assign bus.Write    = w_ctl.write;
  assign bus.halted   = (r_state == S_HALTED);
  assign bus.fault    = r_fault;

endmodule
`default_nettype wire
